// File: rtl/lpddr2_responder.sv
// CPU-side request front end for an LPDDR2 Avalon-MM backend: edge-triggered
// read/write requests, one outstanding command, read timeout and sticky error.
module lpddr2_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] address,
  input  logic [31:0] write_data,
  input  logic        read_req,
  input  logic        write_req,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [26:0] avl_address,
  output logic [31:0] avl_writedata,
  output logic        avl_read,
  output logic        avl_write,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid
);

  localparam int unsigned AW = 27;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic          pending_rd_q, pending_rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] read_data_q, read_data_d;
  logic [AW-1:0] avl_address_q, avl_address_d;
  logic [DW-1:0] avl_writedata_q, avl_writedata_d;
  logic          avl_read_q, avl_read_d;
  logic          avl_write_q, avl_write_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic rd_edge_c;
  logic wr_edge_c;

  assign rd_edge_c = read_req & ~rd_req_q;
  assign wr_edge_c = write_req & ~wr_req_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d         = state_q;
    rd_req_d        = read_req;
    wr_req_d        = write_req;
    pending_rd_d    = pending_rd_q;
    cnt_d           = cnt_q;
    read_data_d     = read_data_q;
    avl_address_d   = avl_address_q;
    avl_writedata_d = avl_writedata_q;
    err_d           = err_q;
    done_d          = (state_q == S_DONE);

    // Any request edge outside IDLE is dropped for good
    if ((state_q != S_IDLE) && (rd_edge_c || wr_edge_c)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_edge_c) begin
          avl_address_d   = address;
          avl_writedata_d = write_data;
          pending_rd_d    = rd_edge_c;
          state_d         = S_WR_ISSUE;
        end else if (rd_edge_c) begin
          avl_address_d = address;
          state_d       = S_RD_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        if (avl_write_q && !avl_waitrequest) begin
          state_d = S_DONE;
        end
      end
      S_RD_ISSUE: begin
        if (avl_read_q && !avl_waitrequest) begin
          cnt_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (avl_readdatavalid) begin
          read_data_d = avl_readdata;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            read_data_d = ERR_WORD;
            err_d       = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (pending_rd_q) begin
          pending_rd_d = 1'b0;
          state_d      = S_RD_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and busy track the state being entered so they align with it
    avl_read_d  = (state_d == S_RD_ISSUE);
    avl_write_d = (state_d == S_WR_ISSUE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rd_req_q        <= 1'b0;
      wr_req_q        <= 1'b0;
      pending_rd_q    <= 1'b0;
      cnt_q           <= '0;
      read_data_q     <= '0;
      avl_address_q   <= '0;
      avl_writedata_q <= '0;
      avl_read_q      <= 1'b0;
      avl_write_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_req_q        <= rd_req_d;
      wr_req_q        <= wr_req_d;
      pending_rd_q    <= pending_rd_d;
      cnt_q           <= cnt_d;
      read_data_q     <= read_data_d;
      avl_address_q   <= avl_address_d;
      avl_writedata_q <= avl_writedata_d;
      avl_read_q      <= avl_read_d;
      avl_write_q     <= avl_write_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign read_data     = read_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign avl_address   = avl_address_q;
  assign avl_writedata = avl_writedata_q;
  assign avl_read      = avl_read_q;
  assign avl_write     = avl_write_q;

endmodule
